led_counter_bank: RTL and testbench

//  Multi-channel, parametrised up/down counter bank for the LED blink designs.

---
 rtl/led_counter_bank.sv | 119 +++++++++++
 tb/tb_led_counter_bank.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/led_counter_bank.sv
// Multi-channel up/down counter bank with a prescaler tick, a wrap/saturate mode,
// a synchronous load, and a registered LED decode of one selected channel.
module led_counter_bank #(
  parameter int DIV      = 12000000,
  parameter int CH       = 4,
  parameter int WIDTH    = 8,
  parameter int LEDS     = 16,
  parameter int LED_MODE = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [CH-1:0]                       direction,
  input  logic                                saturate,
  input  logic                                load,
  input  logic [WIDTH-1:0]                    load_val,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] sel,
  output logic                                tick,
  output logic [CH*WIDTH-1:0]                 count,
  output logic [CH-1:0]                       wrap,
  output logic [LEDS-1:0]                     led
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] cnt_q [CH];
  logic [WIDTH-1:0] cnt_d [CH];
  logic [CH-1:0]    dir_q, dir_d;
  logic [CH-1:0]    wrap_q, wrap_d;
  logic [LEDS-1:0]  led_q, led_d;

  // Thermometer mode has LEDS+1 distinct patterns (all off .. all on).
  function automatic logic [LEDS-1:0] decode(input logic [WIDTH-1:0] c);
    logic [LEDS-1:0] d;
    int v;
    v = int'(c) % ((LED_MODE != 0) ? (LEDS + 1) : LEDS);
    for (int i = 0; i < LEDS; i++) begin
      d[i] = (LED_MODE != 0) ? (i < v) : (i == v);
    end
    return d;
  endfunction

  always_comb begin
    int sel_idx;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    wrap_d  = '0;
    sel_idx = (int'(sel) < CH) ? int'(sel) : 0;
    led_d   = decode(cnt_q[sel_idx]);

    if (load) begin
      pre_d = '0;
      for (int n = 0; n < CH; n++) cnt_d[n] = load_val;
    end else begin
      if (enable) begin
        if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          tick_d = 1'b1;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      // Step with the direction captured at the previous step, then capture anew.
      if (tick_q) begin
        dir_d = direction;
        for (int n = 0; n < CH; n++) begin
          if (dir_q[n]) begin
            if (cnt_q[n] == CNT_MAX) begin
              wrap_d[n] = 1'b1;
              cnt_d[n]  = saturate ? CNT_MAX : '0;
            end else begin
              cnt_d[n]  = cnt_q[n] + 1'b1;
            end
          end else begin
            if (cnt_q[n] == '0) begin
              wrap_d[n] = 1'b1;
              cnt_d[n]  = saturate ? '0 : CNT_MAX;
            end else begin
              cnt_d[n]  = cnt_q[n] - 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      for (int n = 0; n < CH; n++) cnt_q[n] <= '0;
      dir_q  <= '0;
      wrap_q <= '0;
      led_q  <= decode('0);
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      led_q  <= led_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign count[g*WIDTH +: WIDTH] = cnt_q[g];
  end

  assign tick = tick_q;
  assign wrap = wrap_q;
  assign led  = led_q;

endmodule

// File: tb/tb_led_counter_bank.sv
// Randomized and directed bench for led_counter_bank; one-hot and thermometer
// instances share stimulus and are compared against a cycle model.
module tb_led_counter_bank;
  localparam int DIV = 4, CH = 2, WIDTH = 4, LEDS = 8, MAXV = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0, enable = 1'b0, saturate = 1'b0, load = 1'b0;
  logic [1:0] direction = 2'b00;
  logic [3:0] load_val = 4'h0;
  logic [0:0] sel = 1'b0;

  logic       tick, tick2;
  logic [7:0] count, count2;
  logic [1:0] wrap, wrap2;
  logic [7:0] led, led2;

  led_counter_bank #(.DIV(DIV), .CH(CH), .WIDTH(WIDTH), .LEDS(LEDS), .LED_MODE(0)) dut_oh (
    .clk(clk), .reset(reset), .enable(enable), .direction(direction), .saturate(saturate),
    .load(load), .load_val(load_val), .sel(sel),
    .tick(tick), .count(count), .wrap(wrap), .led(led));

  led_counter_bank #(.DIV(DIV), .CH(CH), .WIDTH(WIDTH), .LEDS(LEDS), .LED_MODE(1)) dut_th (
    .clk(clk), .reset(reset), .enable(enable), .direction(direction), .saturate(saturate),
    .load(load), .load_val(load_val), .sel(sel),
    .tick(tick2), .count(count2), .wrap(wrap2), .led(led2));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle model: counter values as integers, per-tick rules in plain arithmetic.
  int m_pre = 0, m_tick = 0, m_src = 0;
  int m_cnt [2] = '{0, 0};
  int m_dir [2] = '{0, 0};
  int m_wrap[2] = '{0, 0};

  function automatic int exp_onehot(input int c);
    return 1 << (c % LEDS);
  endfunction

  function automatic int exp_therm(input int c);
    return (1 << (c % (LEDS + 1))) - 1;
  endfunction

  task automatic model_update();
    int stepping;
    if (!reset) begin
      m_pre = 0; m_tick = 0; m_src = 0;
      for (int n = 0; n < 2; n++) begin m_cnt[n] = 0; m_dir[n] = 0; m_wrap[n] = 0; end
    end else begin
      m_src    = m_cnt[(int'(sel) >= CH) ? 0 : int'(sel)];
      stepping = m_tick;
      for (int n = 0; n < 2; n++) m_wrap[n] = 0;
      if (load) begin
        m_pre = 0; m_tick = 0;
        for (int n = 0; n < 2; n++) m_cnt[n] = int'(load_val);
      end else begin
        m_tick = (enable && m_pre == DIV - 1) ? 1 : 0;
        if (enable) m_pre = (m_pre + 1) % DIV;
        if (stepping != 0) begin
          for (int n = 0; n < 2; n++) begin
            if (m_dir[n] != 0) begin
              if (m_cnt[n] == MAXV) begin m_wrap[n] = 1; m_cnt[n] = saturate ? MAXV : 0; end
              else m_cnt[n] = m_cnt[n] + 1;
            end else begin
              if (m_cnt[n] == 0) begin m_wrap[n] = 1; m_cnt[n] = saturate ? 0 : MAXV; end
              else m_cnt[n] = m_cnt[n] - 1;
            end
            m_dir[n] = int'(direction[n]);
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    check("tick",  64'(tick),   64'(m_tick));
    check("count", 64'(count),  64'(m_cnt[0] + 16 * m_cnt[1]));
    check("wrap",  64'(wrap),   64'(m_wrap[0] + 2 * m_wrap[1]));
    check("led_oh", 64'(led),   64'(exp_onehot(m_src)));
    check("tick_th",  64'(tick2),  64'(m_tick));
    check("count_th", 64'(count2), 64'(m_cnt[0] + 16 * m_cnt[1]));
    check("led_th", 64'(led2),  64'(exp_therm(m_src)));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int k;
    int saved;
    // Reset state
    reset = 1'b0; enable = 1'b1; direction = 2'b11;
    run(2);
    check("rst_led_oh", 64'(led), 64'h01);
    check("rst_led_th", 64'(led2), 64'h00);

    // Test 1: ticks at 4,8,12; ch0 0->15->0->1
    reset = 1'b1;
    run(3); check("t1_notick3", 64'(tick), 64'd0);
    run(1); check("t1_tick4", 64'(tick), 64'd1);
    run(1); check("t1_c15", 64'(count[3:0]), 64'd15); check("t1_w1", 64'(wrap), 64'd3);
    run(4); check("t1_c0", 64'(count[3:0]), 64'd0);   check("t1_w2", 64'(wrap), 64'd3);
    run(4); check("t1_c1", 64'(count[3:0]), 64'd1);   check("t1_w3", 64'(wrap), 64'd0);

    // Test 2: saturate at MAX
    saturate = 1'b1; load_val = 4'hE; load = 1'b1; cyc(); load = 1'b0;
    check("t2_load", 64'(count), 64'hEE);
    run(5); check("t2_c15", 64'(count[3:0]), 64'd15); check("t2_w0", 64'(wrap), 64'd0);
    run(1); check("t2_led7", 64'(led[7]), 64'd1);
    run(3); check("t2_hold", 64'(count[3:0]), 64'd15); check("t2_wsat", 64'(wrap), 64'd3);

    // Test 3: load on a step cycle
    k = 0;
    while (m_tick == 0 && k < 20) begin cyc(); k++; end
    check("t3_find_tick", 64'(m_tick), 64'd1);
    saturate = 1'b0; load_val = 4'h5; load = 1'b1; cyc(); load = 1'b0;
    check("t3_cnt", 64'(count), 64'h55); check("t3_wrap", 64'(wrap), 64'd0);
    run(3); check("t3_notick", 64'(tick), 64'd0);
    run(1); check("t3_tick", 64'(tick), 64'd1);

    // Test 4: freeze at pre==2
    k = 0;
    while (m_pre != 2 && k < 20) begin cyc(); k++; end
    check("t4_find_pre", 64'(m_pre), 64'd2);
    saved = int'(count);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin cyc(); check("t4_frz_tick", 64'(tick), 64'd0); end
    check("t4_frz_cnt", 64'(count), 64'(saved));
    enable = 1'b1;
    run(1); check("t4_re1", 64'(tick), 64'd0);
    run(1); check("t4_re2", 64'(tick), 64'd1);

    // Test 5: thermometer decode
    enable = 1'b0; sel = 1'b0;
    load_val = 4'd3; load = 1'b1; cyc(); load = 1'b0; cyc(); check("t5_th3", 64'(led2), 64'h07);
    load_val = 4'd8; load = 1'b1; cyc(); load = 1'b0; cyc(); check("t5_th8", 64'(led2), 64'hFF);
    load_val = 4'd9; load = 1'b1; cyc(); load = 1'b0; cyc(); check("t5_th9", 64'(led2), 64'h00);
    check("t5_oh9", 64'(led), 64'h02);

    // Test 6: reset mid-period
    enable = 1'b1; load_val = 4'd7; load = 1'b1; cyc(); load = 1'b0;
    run(3); check("t6_cnt7", 64'(count), 64'h77);
    reset = 1'b0; cyc(); reset = 1'b1;
    check("t6_rcnt", 64'(count), 64'd0); check("t6_rtick", 64'(tick), 64'd0);
    for (int i = 1; i < 4; i++) begin cyc(); check("t6_notick", 64'(tick), 64'd0); end
    run(1); check("t6_tick", 64'(tick), 64'd1);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      load      = ($urandom_range(0, 15) == 0);
      load_val  = 4'($urandom_range(0, 15));
      direction = 2'($urandom_range(0, 3));
      saturate  = 1'($urandom_range(0, 1));
      sel       = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
